// File: rtl/mpt_pkg.sv
// Shared types and limits for the MPT pipeline controller: per-stage flush
// commands, controller FSM states and parameter range limits.
package mpt_pkg;

  typedef enum logic [1:0] {
    MPT_FLUSH_NONE = 2'd0,
    MPT_FLUSH_SPEC = 2'd1,
    MPT_FLUSH_ALL  = 2'd2
  } mptw_flush_ctrl_e;

  typedef enum logic [2:0] {
    MPT_ST_IDLE        = 3'd0,
    MPT_ST_RUNNING     = 3'd1,
    MPT_ST_FLUSH       = 3'd2,
    MPT_ST_SPEC_FLUSH  = 3'd3,
    MPT_ST_STALL       = 3'd4,
    MPT_ST_STALL_FLUSH = 3'd5
  } mpt_state_e;

  localparam int unsigned MPT_MAX_INFLIGHT_DEF = 4;
  localparam int unsigned MPT_MAX_INFLIGHT_MIN = 1;
  localparam int unsigned MPT_MAX_INFLIGHT_LIM = 255;
  localparam int unsigned MPT_NUM_STAGES_MIN   = 2;
  localparam int unsigned MPT_NUM_STAGES_MAX   = 32;

  // States in which the global stage-enable is dropped.
  function automatic logic is_stall_state(input mpt_state_e s);
    return (s == MPT_ST_STALL) || (s == MPT_ST_STALL_FLUSH);
  endfunction

endpackage

// File: rtl/mpt_inflight_counter.sv
// Saturation-safe up/down counter of in-flight transactions with a
// synchronous clear used when a full flush completes.
module mpt_inflight_counter
  import mpt_pkg::*;
#(
  parameter int unsigned MAX = MPT_MAX_INFLIGHT_DEF,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Simultaneous inc/dec leaves the count unchanged; never wraps either way.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && !dec && (count < W'(MAX))) begin
      count <= count + W'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/mpt_pipeline_ctrl.sv
// Pipeline controller for the MPT walker: gates system handshakes, sequences
// flush/stall and tracks in-flight work. Optional MPT_PIPELINE_CTRL_PERF_EN
// adds saturating stall-cycle and completed-flush counters.
module mpt_pipeline_ctrl
  import mpt_pkg::*;
#(
  parameter int unsigned NUM_STAGES   = 8,
  parameter int unsigned MAX_INFLIGHT = MPT_MAX_INFLIGHT_DEF,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                                           clk_i,
  input  logic                                           rst_i,
  input  logic                                           valid_req_i,
  input  logic                                           pipeline_valid_i,
  input  logic                                           pipeline_ready_i,
  output logic                                           system_valid_o,
  output logic                                           system_ready_o,
  input  logic                                           retire_valid_i,
  input  logic                                           flush_all_i,
  input  logic                                           flush_spec_i,
  input  logic                                           stall_i,
  output logic [NUM_STAGES*$bits(mptw_flush_ctrl_e)-1:0] stage_flush_o,
  input  logic [NUM_STAGES-1:0]                          stage_flush_done_i,
  input  logic [NUM_STAGES-1:0]                          stage_error_i,
  output logic                                           advance_o,
  output logic                                           busy_o,
  output logic                                           stalled_o,
  output logic                                           error_o,
  output logic [$clog2(NUM_STAGES)-1:0]                  err_stage_o,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]              inflight_o
`ifdef MPT_PIPELINE_CTRL_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]                           stall_cycles_o,
  output logic [CNT_WIDTH-1:0]                           flush_count_o
`endif
);

  localparam int unsigned SW = $clog2(NUM_STAGES);
  localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);

  if ((NUM_STAGES < MPT_NUM_STAGES_MIN) || (NUM_STAGES > MPT_NUM_STAGES_MAX)) begin : g_bad_stages
    $error("mpt_pipeline_ctrl: NUM_STAGES out of range");
  end
  if ((MAX_INFLIGHT < MPT_MAX_INFLIGHT_MIN) || (MAX_INFLIGHT > MPT_MAX_INFLIGHT_LIM)) begin : g_bad_inflight
    $error("mpt_pipeline_ctrl: MAX_INFLIGHT out of range");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt
    $error("mpt_pipeline_ctrl: CNT_WIDTH must be positive");
  end

  mpt_state_e       state, state_nxt;
  logic             pending, pending_nxt;
  logic             error_q;
  logic [SW-1:0]    err_stage_q, err_idx;
  logic [IW-1:0]    inflight;
  logic             err_any, done_all, trans_cond, run_st, stall_st;
  logic             ready_c, accept, clr_cnt;
  mptw_flush_ctrl_e flush_cmd;

  mpt_inflight_counter #(
    .MAX (MAX_INFLIGHT),
    .W   (IW)
  ) u_inflight (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (accept),
    .dec   (retire_valid_i),
    .clr   (clr_cnt),
    .count (inflight)
  );

  // Handshake gating and lowest-index error encoder.
  always_comb begin
    err_any    = |stage_error_i;
    done_all   = &stage_flush_done_i;
    run_st     = (state == MPT_ST_IDLE) || (state == MPT_ST_RUNNING);
    stall_st   = is_stall_state(state);
    trans_cond = flush_all_i || err_any || flush_spec_i || stall_i || !pipeline_ready_i;
    ready_c    = !rst_i && run_st && !trans_cond && (inflight < IW'(MAX_INFLIGHT));
    accept     = valid_req_i && ready_c;
    err_idx    = '0;
    for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
      if (stage_error_i[i]) err_idx = SW'(i);
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    clr_cnt     = 1'b0;
    case (state)
      MPT_ST_IDLE, MPT_ST_RUNNING: begin
        pending_nxt = 1'b0;
        if (flush_all_i)                       state_nxt = MPT_ST_FLUSH;
        else if (err_any)                      state_nxt = MPT_ST_STALL_FLUSH;
        else if (flush_spec_i)                 state_nxt = MPT_ST_SPEC_FLUSH;
        else if (stall_i || !pipeline_ready_i) state_nxt = MPT_ST_STALL;
        else if ((inflight == '0) && !accept)  state_nxt = MPT_ST_IDLE;
        else                                   state_nxt = MPT_ST_RUNNING;
      end
      // A full flush ignores speculative requests and new errors until done.
      MPT_ST_FLUSH, MPT_ST_STALL_FLUSH: begin
        if (done_all) begin
          state_nxt = stall_i ? MPT_ST_STALL : MPT_ST_IDLE;
          clr_cnt   = 1'b1;
        end
      end
      MPT_ST_SPEC_FLUSH: begin
        if (flush_all_i)   state_nxt = MPT_ST_FLUSH;
        else if (done_all) state_nxt = stall_i ? MPT_ST_STALL : MPT_ST_IDLE;
      end
      MPT_ST_STALL: begin
        if (flush_all_i || err_any) begin
          state_nxt   = MPT_ST_STALL_FLUSH;
          pending_nxt = 1'b0;
        end else if (!stall_i && pipeline_ready_i) begin
          if (pending || flush_spec_i) begin
            state_nxt   = MPT_ST_SPEC_FLUSH;
            pending_nxt = 1'b0;
          end else begin
            state_nxt = (inflight != '0) ? MPT_ST_RUNNING : MPT_ST_IDLE;
          end
        end else if (flush_spec_i) begin
          pending_nxt = 1'b1;
        end
      end
      default: state_nxt = MPT_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= MPT_ST_IDLE;
      pending     <= 1'b0;
      error_q     <= 1'b0;
      err_stage_q <= '0;
    end else begin
      state       <= state_nxt;
      pending     <= pending_nxt;
      error_q     <= err_any;
      if (err_any) err_stage_q <= err_idx;
    end
  end

  // Outputs decode the state; reset forces the quiescent values immediately.
  always_comb begin
    flush_cmd = MPT_FLUSH_NONE;
    if (!rst_i) begin
      case (state)
        MPT_ST_FLUSH, MPT_ST_STALL_FLUSH: flush_cmd = MPT_FLUSH_ALL;
        MPT_ST_SPEC_FLUSH:               flush_cmd = MPT_FLUSH_SPEC;
        default:                         flush_cmd = MPT_FLUSH_NONE;
      endcase
    end
    stage_flush_o  = {NUM_STAGES{flush_cmd}};
    system_ready_o = ready_c;
    system_valid_o = !rst_i && run_st && pipeline_valid_i;
    advance_o      = rst_i || !stall_st;
    stalled_o      = !rst_i && stall_st;
    busy_o         = !rst_i && ((state != MPT_ST_IDLE) || (inflight != '0));
    error_o        = !rst_i && error_q;
    err_stage_o    = rst_i ? '0 : err_stage_q;
    inflight_o     = rst_i ? '0 : inflight;
  end

`ifdef MPT_PIPELINE_CTRL_PERF_EN
  logic flush_done;

  always_comb begin
    flush_done = done_all && ((state == MPT_ST_FLUSH) || (state == MPT_ST_STALL_FLUSH) ||
                              ((state == MPT_ST_SPEC_FLUSH) && !flush_all_i));
  end

  // Saturating performance counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cycles_o <= '0;
      flush_count_o  <= '0;
    end else begin
      if (stall_st && (stall_cycles_o != '1)) stall_cycles_o <= stall_cycles_o + CNT_WIDTH'(1);
      if (flush_done && (flush_count_o != '1)) flush_count_o <= flush_count_o + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mpt_pipeline_ctrl.sv
// Self-checking bench for mpt_pipeline_ctrl: directed scenarios followed by
// randomized traffic, all compared every cycle against a flag-based model.
module tb_mpt_pipeline_ctrl;
  import mpt_pkg::*;

  localparam int NS = 8;
  localparam int MI = 4;

  logic clk = 1'b0;
  logic rst, valid_req, pvalid, pready, sys_valid, sys_ready, retire;
  logic fa, fs, stall, advance, busy, stalled, error;
  logic [2*NS-1:0] sflush;
  logic [NS-1:0]   done, serr;
  logic [2:0]      err_stage, inflight;
`ifdef MPT_PIPELINE_CTRL_PERF_EN
  logic [31:0]     stall_cycles, flush_count;
`endif

  int checks = 0;
  int failures = 0;

  // Model: flushing/all/frozen flags describe the controller mode.
  bit m_flushing, m_all, m_frozen, m_running, m_pend, m_err_q;
  int m_cnt, m_err_stage;
  bit e_ready;

  mpt_pipeline_ctrl #(.NUM_STAGES(NS), .MAX_INFLIGHT(MI), .CNT_WIDTH(32)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .valid_req_i        (valid_req),
    .pipeline_valid_i   (pvalid),
    .pipeline_ready_i   (pready),
    .system_valid_o     (sys_valid),
    .system_ready_o     (sys_ready),
    .retire_valid_i     (retire),
    .flush_all_i        (fa),
    .flush_spec_i       (fs),
    .stall_i            (stall),
    .stage_flush_o      (sflush),
    .stage_flush_done_i (done),
    .stage_error_i      (serr),
    .advance_o          (advance),
    .busy_o             (busy),
    .stalled_o          (stalled),
    .error_o            (error),
    .err_stage_o        (err_stage),
`ifdef MPT_PIPELINE_CTRL_PERF_EN
    .stall_cycles_o     (stall_cycles),
    .flush_count_o      (flush_count),
`endif
    .inflight_o         (inflight)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [NS-1:0] v);
    for (int i = 0; i < NS; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [2*NS-1:0] all_cmd(input mptw_flush_ctrl_e c);
    logic [1:0] b;
    b = c;
    return {NS{b}};
  endfunction

  task automatic check_model();
    bit idle_run, trans;
    logic [1:0] cmd;
    idle_run = !m_flushing && !m_frozen;
    trans    = fa || (serr != '0) || fs || stall || !pready;
    e_ready  = !rst && idle_run && !trans && (m_cnt < MI);
    cmd      = (rst || !m_flushing) ? 2'd0 : (m_all ? 2'd2 : 2'd1);
    cmp("ready",     32'(sys_ready), 32'(e_ready));
    cmp("valid",     32'(sys_valid), 32'(!rst && idle_run && pvalid));
    cmp("advance",   32'(advance),   32'(rst || !m_frozen));
    cmp("stalled",   32'(stalled),   32'(!rst && m_frozen));
    cmp("busy",      32'(busy),      32'(!rst && (!(idle_run && !m_running) || m_cnt != 0)));
    cmp("flush",     32'(sflush),    32'({NS{cmd}}));
    cmp("inflight",  32'(inflight),  rst ? 0 : m_cnt);
    cmp("error",     32'(error),     32'(!rst && m_err_q));
    cmp("err_stage", 32'(err_stage), rst ? 0 : m_err_stage);
  endtask

  task automatic model_update();
    bit acc, clr;
    if (rst) begin
      {m_flushing, m_all, m_frozen, m_running, m_pend, m_err_q} = '0;
      m_cnt = 0;
      m_err_stage = 0;
      return;
    end
    acc = valid_req && e_ready;
    clr = 1'b0;
    m_err_q = (serr != '0);
    if (serr != '0) m_err_stage = lowest(serr);
    if (!m_flushing && !m_frozen) begin
      m_pend = 1'b0;
      if (fa) begin m_flushing = 1; m_all = 1; end
      else if (serr != '0) begin m_flushing = 1; m_all = 1; m_frozen = 1; end
      else if (fs) begin m_flushing = 1; m_all = 0; end
      else if (stall || !pready) m_frozen = 1;
      else m_running = !(m_cnt == 0 && !acc);
    end else if (m_flushing) begin
      if (!m_all && fa) m_all = 1;
      else if (done == '1) begin
        clr = m_all; m_flushing = 0; m_frozen = stall; m_running = 0;
      end
    end else begin
      if (fa || serr != '0) begin m_flushing = 1; m_all = 1; m_pend = 0; end
      else if (!stall && pready) begin
        m_frozen = 0;
        if (m_pend || fs) begin m_flushing = 1; m_all = 0; m_pend = 0; end
        else m_running = (m_cnt != 0);
      end else if (fs) m_pend = 1;
    end
    if (clr) m_cnt = 0;
    else if (acc && !retire) m_cnt++;
    else if (retire && !acc && m_cnt > 0) m_cnt--;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic tick();
    check_model();
    model_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; valid_req = 0; pvalid = 0; pready = 1; retire = 0;
    fa = 0; fs = 0; stall = 0; done = '0; serr = '0;
    @(posedge clk); @(posedge clk); #1;

    // Reset values.
    settle();
    cmp("rst_adv", 32'(advance), 1);
    cmp("rst_rdy", 32'(sys_ready), 0);
    cmp("rst_flush", 32'(sflush), 0);
    tick();
    rst = 0;

    // Four back-to-back accepts fill the window; one retire reopens it.
    valid_req = 1; pvalid = 1;
    repeat (4) begin settle(); tick(); end
    settle();
    cmp("full_cnt", 32'(inflight), 4);
    cmp("full_rdy", 32'(sys_ready), 0);
    tick();
    valid_req = 0; retire = 1;
    settle(); tick();
    retire = 0;
    settle();
    cmp("reopen_rdy", 32'(sys_ready), 1);
    tick();

    // Flush-all from RUNNING with three in flight; done after five cycles.
    fa = 1;
    settle(); cmp("fa_rdy", 32'(sys_ready), 0); tick();
    fa = 0;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) done = '1;
      settle();
      cmp("fa_cmd", 32'(sflush), 32'(all_cmd(MPT_FLUSH_ALL)));
      cmp("fa_rdy_hold", 32'(sys_ready), 0);
      tick();
    end
    done = '0;
    settle();
    cmp("fa_cnt0", 32'(inflight), 0);
    cmp("fa_idle", 32'(busy), 0);
    tick();

    // Speculative flush requested during a stall is deferred to release.
    stall = 1;
    settle(); tick();
    fs = 1;
    settle();
    cmp("st_adv", 32'(advance), 0);
    cmp("st_stalled", 32'(stalled), 1);
    tick();
    fs = 0;
    repeat (2) begin settle(); tick(); end
    stall = 0;
    settle(); tick();
    settle();
    cmp("spec_cmd", 32'(sflush), 32'(all_cmd(MPT_FLUSH_SPEC)));
    cmp("spec_adv", 32'(advance), 1);
    done = '1;
    tick();
    done = '0;

    // Stage error in RUNNING reports lowest index and enters STALL_FLUSH.
    valid_req = 1;
    settle(); tick();
    valid_req = 0; serr = 8'b0010_0100;
    settle(); tick();
    serr = '0;
    settle();
    cmp("err_pulse", 32'(error), 1);
    cmp("err_idx", 32'(err_stage), 2);
    cmp("err_stalled", 32'(stalled), 1);
    cmp("err_cmd", 32'(sflush), 32'(all_cmd(MPT_FLUSH_ALL)));
    tick();
    settle();
    cmp("err_once", 32'(error), 0);
    cmp("err_hold", 32'(err_stage), 2);
    done = '1;
    tick();
    done = '0;
    settle(); tick();

    // Both flush requests together act as flush-all; reset abandons it.
    fa = 1; fs = 1;
    settle(); tick();
    fa = 0; fs = 0;
    settle();
    cmp("both_cmd", 32'(sflush), 32'(all_cmd(MPT_FLUSH_ALL)));
    tick();
    rst = 1;
    settle();
    cmp("rstmid_cmd", 32'(sflush), 0);
    tick();
    rst = 0;
    settle();
    cmp("rstmid_none", 32'(sflush), 0);
    cmp("rstmid_busy", 32'(busy), 0);
    tick();

    // Randomized traffic.
    for (int n = 0; n < 2500; n++) begin
      valid_req = 1'($urandom_range(0, 1));
      pvalid    = 1'($urandom_range(0, 1));
      pready    = ($urandom_range(0, 9) != 0);
      retire    = ($urandom_range(0, 9) < 3);
      fa        = ($urandom_range(0, 99) < 3);
      fs        = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 9) == 0) stall = !stall;
      serr      = ($urandom_range(0, 99) < 3) ? NS'($urandom_range(1, 255)) : '0;
      done      = ($urandom_range(0, 9) < 3) ? '1 : NS'($urandom);
      rst       = ($urandom_range(0, 299) == 0);
      settle();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mpt_pipeline_ctrl.md
MPT_PIPELINE_CTRL -- requirements
Module: mpt_pipeline_ctrl

Interface
REQ-001 Parameter NUM_STAGES, default 8: number of controlled stages (fetch, issue, PLB lookup, walking levels, retire), range 2..32.
REQ-002 Parameter MAX_INFLIGHT, default 4: maximum in-flight transactions, range 1..255.
REQ-003 Parameter CNT_WIDTH, default 32: performance counter width.
REQ-004 clk_i  in  1  single clock; all logic on rising edge.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 valid_req_i  in  1  new request offered by the system.
REQ-007 pipeline_valid_i / pipeline_ready_i  in  1 each  pipeline output valid / pipeline can accept.
REQ-008 system_valid_o / system_ready_o  out  1 each  gated valid to the system / gated ready to the system.
REQ-009 retire_valid_i  in  1  one transaction left the pipeline, retired or killed.
REQ-010 flush_all_i, flush_spec_i, stall_i  in  1 each  external flush-all, speculative flush and stall.
REQ-011 stage_flush_o  out  NUM_STAGES x $bits(mptw_flush_ctrl_e)  per-stage flush command.
REQ-012 stage_flush_done_i  in  NUM_STAGES  stage has completed the commanded flush.
REQ-013 stage_error_i  in  NUM_STAGES  stage error strobe.
REQ-014 advance_o  out  1  global stage-enable; low freezes every stage.
REQ-015 busy_o, stalled_o, error_o  out  1 each  busy, stalled, one-cycle error strobe.
REQ-016 err_stage_o  out  $clog2(NUM_STAGES)  index of the last reported erroring stage.
REQ-017 inflight_o  out  $clog2(MAX_INFLIGHT+1)  current in-flight count.

Function
REQ-018 FSM states: IDLE, RUNNING, FLUSH, SPEC_FLUSH, STALL, STALL_FLUSH.
REQ-019 IDLE/RUNNING priority (highest first): flush_all_i -> FLUSH; any stage_error_i -> STALL_FLUSH; flush_spec_i -> SPEC_FLUSH; stall_i or ~pipeline_ready_i -> STALL; otherwise IDLE if inflight==0 and no accept this cycle, else RUNNING.
REQ-020 Accept = valid_req_i && system_ready_o; inflight +1 on accept, -1 on retire_valid_i, unchanged when both occur in the same cycle.
REQ-021 system_ready_o = pipeline_ready_i && inflight<MAX_INFLIGHT, only in IDLE/RUNNING with no transition condition active; otherwise 0.
REQ-022 system_valid_o = pipeline_valid_i in IDLE/RUNNING; 0 in all other states.
REQ-023 advance_o = 1 in IDLE, RUNNING, FLUSH, SPEC_FLUSH; 0 in STALL, STALL_FLUSH.
REQ-024 In FLUSH/STALL_FLUSH every stage_flush_o = MPT_FLUSH_ALL; in SPEC_FLUSH = MPT_FLUSH_SPEC; otherwise MPT_FLUSH_NONE. Commands are held, not pulsed.
REQ-025 A flush completes in the first cycle in which stage_flush_done_i is all ones; the next state is STALL if stall_i is high, else IDLE.
REQ-026 On FLUSH/STALL_FLUSH completion inflight is forced to 0; SPEC_FLUSH relies on retire_valid_i for killed transactions.
REQ-027 flush_all_i during SPEC_FLUSH -> FLUSH (upgrade); flush_spec_i during FLUSH is ignored.
REQ-028 STALL: flush_all_i or stage_error_i -> STALL_FLUSH; flush_spec_i sets a pending bit. Exit when stall_i=0 and pipeline_ready_i=1: to SPEC_FLUSH if pending (bit cleared), else RUNNING if inflight>0, else IDLE.
REQ-029 flush_all_i and flush_spec_i high together -> flush-all behaviour, pending bit cleared.
REQ-030 error_o pulses one cycle on the cycle stage_error_i!=0 is sampled; err_stage_o = lowest set index, held until the next error.
REQ-031 busy_o = (state!=IDLE) || inflight!=0; stalled_o = state in {STALL, STALL_FLUSH}.
REQ-032 Errors arriving during FLUSH/STALL_FLUSH are reported but do not restart the flush.

Reset
REQ-033 While rst_i is high: state IDLE, inflight 0, pending bit 0, err_stage_o 0, counters 0, all flush outputs MPT_FLUSH_NONE, all 1-bit outputs 0 except advance_o=1; reset mid-flush abandons the flush.

Configuration
REQ-034 MPT_PIPELINE_CTRL_PERF_EN defined: outputs stall_cycles_o (CNT_WIDTH, +1 per cycle stalled_o=1) and flush_count_o (CNT_WIDTH, +1 per completed flush), both saturating. Undefined: the ports and counters do not exist.

Structure
REQ-035 mptw_flush_ctrl_e, the FSM state enum and MAX_INFLIGHT limit constants SHALL reside in mpt_pkg.
REQ-036 Sub-module mpt_inflight_counter (up/down, clear, saturation-safe) SHALL implement REQ-020/REQ-026.

Verification
REQ-037 4 back-to-back accepts, no retire -> inflight_o=4, system_ready_o=0 in 5th cycle; one retire -> ready 1.
REQ-038 RUNNING, inflight=3, flush_all_i 1 cycle, done bits after 5 cycles -> stage_flush_o=ALL for 5 cycles, then IDLE, inflight 0, system_ready_o 0 throughout.
REQ-039 stall_i high + flush_spec_i pulse, stall released 4 cycles later -> STALL, advance_o=0, then SPEC_FLUSH on release.
REQ-040 stage_error_i=8'b0010_0100 in RUNNING -> error_o 1 cycle, err_stage_o=2, STALL_FLUSH.
REQ-041 flush_all_i and flush_spec_i together -> FLUSH, stage_flush_o=ALL; rst_i mid-flush -> IDLE, NONE next cycle.
